// File: rtl/pos_uart_tx.sv
// pos_uart_tx: transmit side of the 10-bit position link.
// An accepted word goes out as two UART 8N1 bytes, LSB first:
//   H = {1'b1, 4'b0000, data[9:7]}, then L = {1'b0, data[6:0]}.
// Bit 7 marks the high byte, so a receiver can resynchronise on any byte.
//
// Handshake: a word transfers on a rising edge where i_valid & o_ready.
// o_ready is high only in IDLE. i_valid while not ready is ignored and nothing is queued.
// The FSM state is held in r_state so it can be probed directly.
module pos_uart_tx #(
  parameter int DATAW     = 10,
  parameter int SETUPW    = 24,
  parameter int STOP_BITS = 1
) (
  input  logic              i_clk,
  input  logic              n_btn_rst,
  input  logic [SETUPW-1:0] i_setup,
  input  logic              i_valid,
  input  logic [DATAW-1:0]  i_data,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_uart_tx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [SETUPW-1:0] MIN_DIV   = SETUPW'(4);
  // Index of the last stop bit: 0 for one stop bit, 1 for two.
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  state_t            r_state;
  logic [SETUPW-1:0] r_div;     // clocks per bit, latched at acceptance
  logic [SETUPW-1:0] r_cnt;     // clocks left in the current bit, minus one
  logic [2:0]        r_bit;     // data bit index, wraps 7->0 into STOP
  logic              r_stop;    // stop bit index
  logic              r_second;  // 1 while the low byte is being sent
  logic [7:0]        r_shift;   // byte being serialised, LSB at bit 0
  logic [6:0]        r_low;     // low byte payload, held during byte H
  logic              r_tx;
  logic              r_ready;
  logic              r_busy;

  logic [SETUPW-1:0] w_div;
  logic [SETUPW-1:0] w_reload;
  logic              w_take;
  logic              w_bit_end;

  // Clamp the requested divisor; very short bits are not meaningful.
  always_comb begin
    w_div     = (i_setup < MIN_DIV) ? MIN_DIV : i_setup;
    w_reload  = r_div - SETUPW'(1);
    w_take    = i_valid & r_ready;
    w_bit_end = (r_cnt == '0);
  end

  // Frame sequencer: every output is registered; reset forces the line high.
  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_stop   <= 1'b0;
      r_second <= 1'b0;
      r_shift  <= '0;
      r_low    <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (w_take) begin
            r_low    <= i_data[6:0];
            r_shift  <= {1'b1, 4'b0000, i_data[9:7]};
            r_div    <= w_div;
            r_cnt    <= w_div - SETUPW'(1);
            r_second <= 1'b0;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
            r_state  <= ST_START;
          end else begin
            r_ready <= 1'b1;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_cnt   <= w_reload;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt - SETUPW'(1);
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= w_reload;
            r_bit   <= r_bit + 3'd1;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_stop  <= 1'b0;
              r_state <= ST_STOP;
            end else begin
              r_tx <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - SETUPW'(1);
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt <= w_reload;
            if (r_stop != STOP_LAST) begin
              r_stop <= 1'b1;
            end else if (!r_second) begin
              // Low byte starts right after the high byte's last stop bit.
              r_second <= 1'b1;
              r_shift  <= {1'b0, r_low};
              r_tx     <= 1'b0;
              r_state  <= ST_START;
            end else begin
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - SETUPW'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready   = r_ready;
  assign o_busy    = r_busy;
  assign o_uart_tx = r_tx;

endmodule
